// File: rtl/float_mul_seq.sv
// ============================================================================
//  Module   : float_mul_seq
//  Purpose  : Multi-cycle IEEE-754 single-precision multiplier with a
//             radix-2 shift-add significand datapath and valid/ready
//             handshakes on both sides.
//  Option   : FMUL_ROUND_NEAREST_EN selects round-to-nearest-even. When the
//             macro is not defined, the result is truncated.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module float_mul_seq #(
  parameter int XLEN  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EXPS_W = EXP_W + 2;
  localparam int CNT_W  = 5;

  localparam logic signed [EXPS_W-1:0] c_BIAS     = EXPS_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXPS_W-1:0] c_EXP_INF  = EXPS_W'((1 << EXP_W) - 1);
  localparam logic signed [EXPS_W-1:0] c_EXP_ZERO = '0;
  localparam logic signed [EXPS_W-1:0] c_EXP_ONE  = EXPS_W'(1);
  localparam logic [CNT_W-1:0]         c_CNT_LAST = CNT_W'(SIG_W - 1);
  localparam logic [XLEN-1:0]          c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_ZERO = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_NAN  = 2'd3;

  logic [2:0]               state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [EXPS_W-1:0] exp_q, exp_d;
  logic [1:0]               spec_q, spec_d;
  logic [PROD_W-1:0]        mcand_q, mcand_d;
  logic [SIG_W-1:0]         mplier_q, mplier_d;
  logic [PROD_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     exc_q, exc_d;

  // ---------------- operand unpack and classification ----------------
  logic [EXP_W-1:0]         w_ea, w_eb;
  logic [MAN_W-1:0]         w_fa, w_fb;
  logic                     w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [SIG_W-1:0]         w_siga, w_sigb;
  logic signed [EXPS_W-1:0] w_exp_sum;
  logic [1:0]               w_spec;

  assign w_ea      = A[XLEN-2 -: EXP_W];
  assign w_eb      = B[XLEN-2 -: EXP_W];
  assign w_fa      = A[MAN_W-1:0];
  assign w_fb      = B[MAN_W-1:0];
  // Denormals are flushed: any exponent-0 operand counts as zero.
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf   = (w_eb == '1) && (w_fb == '0);
  assign w_a_nan   = (w_ea == '1) && (w_fa != '0);
  assign w_b_nan   = (w_eb == '1) && (w_fb != '0);
  assign w_siga    = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_sigb    = w_b_zero ? '0 : {1'b1, w_fb};
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_BIAS;

  always_comb begin
    w_spec = SP_NONE;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_spec = SP_NAN;
    else if (w_a_inf || w_b_inf)
      w_spec = SP_INF;
    else if (w_a_zero || w_b_zero)
      w_spec = SP_ZERO;
  end

  // ---------------- rounding and packing ----------------
  logic [SIG_W-1:0]         w_sig;
  logic                     w_inc;
  logic [SIG_W:0]           w_sum;
  logic                     w_carry;
  logic [MAN_W-1:0]         w_frac;
  logic signed [EXPS_W-1:0] w_exp_r;
  logic [XLEN-1:0]          w_res;
  logic                     w_ovf, w_unf, w_exc;

  assign w_sig = acc_q[PROD_W-2 -: SIG_W];

`ifdef FMUL_ROUND_NEAREST_EN
  logic w_guard;
  logic w_sticky;
  assign w_guard  = acc_q[PROD_W-2-SIG_W];
  assign w_sticky = |acc_q[PROD_W-3-SIG_W:0];
  assign w_inc    = w_guard && (w_sticky || w_sig[0]);
`else
  assign w_inc    = 1'b0;
`endif

  assign w_sum   = {1'b0, w_sig} + {{SIG_W{1'b0}}, w_inc};
  assign w_carry = w_sum[SIG_W];
  assign w_frac  = w_carry ? w_sum[SIG_W-1:1] : w_sum[MAN_W-1:0];
  assign w_exp_r = w_carry ? (exp_q + c_EXP_ONE) : exp_q;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_exc = 1'b0;
    case (spec_q)
      SP_NAN: begin
        w_res = c_QNAN;
        w_exc = 1'b1;
      end
      SP_INF:  w_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: w_res = {sign_q, {(XLEN-1){1'b0}}};
      default: begin
        if (w_exp_r >= c_EXP_INF) begin
          w_ovf = 1'b1;
          w_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_exp_r <= c_EXP_ZERO) begin
          w_unf = 1'b1;
          w_res = {sign_q, {(XLEN-1){1'b0}}};
        end else begin
          w_res = {sign_q, w_exp_r[EXP_W-1:0], w_frac};
        end
      end
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MUL;
      S_MUL:   if (cnt_q == c_CNT_LAST) state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    sign_d   = sign_q;
    exp_d    = exp_q;
    spec_d   = spec_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    exc_d    = exc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = A[XLEN-1] ^ B[XLEN-1];
          exp_d    = w_exp_sum;
          spec_d   = w_spec;
          mcand_d  = {{SIG_W{1'b0}}, w_siga};
          mplier_d = w_sigb;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      S_NORM: begin
        // Shifted-out LSB is folded into bit 0 so it still reaches the sticky bit.
        if (acc_q[PROD_W-1]) begin
          acc_d    = {1'b0, acc_q[PROD_W-1:1]};
          acc_d[0] = acc_q[1] | acc_q[0];
          exp_d    = exp_q + c_EXP_ONE;
        end
      end
      S_ROUND: begin
        result_d = w_res;
        ovf_d    = w_ovf;
        unf_d    = w_unf;
        exc_d    = w_exc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      spec_q   <= SP_NONE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      spec_q   <= spec_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;

endmodule

`default_nettype wire
